// File: rtl/seq_clk_div.sv
// seq_clk_div: programmable 50%-duty clock divider fed by the sequence
// generator. A new divide ratio is accepted only at an output-period
// boundary, so every period is a whole, correctly shaped period. Odd ratios
// get their extra half cycle of high time from a negedge copy of the
// posedge phase register.
module seq_clk_div #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] div_in,
  output logic         div_rdy,
  output logic [W-1:0] cur_div,
  output logic         running,
  output logic         clk_out
);

  localparam logic IDLE = 1'b0;
  localparam logic RUN  = 1'b1;

  logic         state_q, state_d;
  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic         pos_q, pos_d;
  logic         neg_q;
  logic         at_end;
  logic         load_ok;

  // Last cycle of the current period. Only meaningful in RUN, where
  // cur_div_q >= 2, so the subtraction never underflows when it is used.
  assign at_end  = (cnt_q == cur_div_q - W'(1));
  assign div_rdy = (state_q == IDLE) ? en : at_end;
  // Ratios 0 and 1 are stop codes and are never loaded.
  assign load_ok = en && (div_in >= W'(2));

  // Next-state logic: sample the ratio at boundaries, count otherwise.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    cnt_d     = '0;
    cur_div_d = cur_div_q;
    if (div_rdy) begin
      if (load_ok) begin
        state_d   = RUN;
        cur_div_d = div_in;
      end else begin
        state_d   = IDLE;
        cur_div_d = '0;
      end
    end else if (state_q == RUN) begin
      cnt_d = cnt_q + W'(1);
    end
    // High for the first floor(N/2) cycles of each period; a fresh period
    // starts with cnt_d == 0 < h, so the rising edge lands on the load edge.
    pos_d = (state_d == RUN) && (cnt_d < (cur_div_d >> 1));
  end

  // Posedge state: FSM, counter, ratio in effect and the phase register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: non-blocking assignments keep every flop sampling the
      // pre-edge values, independent of statement order.
      state_q   <= IDLE;
      cnt_q     <= '0;
      cur_div_q <= '0;
      pos_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pos_q     <= pos_d;
    end
  end

  // Half-cycle-delayed copy of the phase, used to stretch odd-ratio highs.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  // Single OR of two registers whose edges are half a cycle apart.
  assign clk_out = pos_q | (neg_q & cur_div_q[0]);
  assign cur_div = cur_div_q;
  assign running = (state_q == RUN);

endmodule
